// File: rtl/id_ex_stage_if.sv
// Decode-side and EX-side signal bundle for the ID/EX pipeline register.
// master = decode/regfile/writeback side, slave = id_ex_stage.
interface id_ex_stage_if;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;
  logic        regwrite_d;
  logic        memwrite_d;
  logic        alusrc_d;
  logic [1:0]  resultsrc_d;
  logic [2:0]  alucontrol_d;
  logic [31:0] immext_d;
  logic [4:0]  a1_d;
  logic [4:0]  a2_d;
  logic [31:0] rd1_d;
  logic [31:0] rd2_d;
  logic        regwrite_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
  logic        stall_d;
  logic        valid_e;
  logic        regwrite_e;
  logic        memwrite_e;
  logic        alusrc_e;
  logic [1:0]  resultsrc_e;
  logic [2:0]  alucontrol_e;
  logic [31:0] rd1_e;
  logic [31:0] rd2_e;
  logic [31:0] immext_e;
  logic [31:0] pc_e;
  logic [31:0] pcplus4_e;
  logic [4:0]  rs1_e;
  logic [4:0]  rs2_e;
  logic [4:0]  rd_e;
  logic [15:0] bubble_cnt;

  modport master (
    output instr_d, pc_d, pcplus4_d, valid_d,
    output regwrite_d, memwrite_d, alusrc_d,
    output resultsrc_d, alucontrol_d, immext_d,
    output rd1_d, rd2_d,
    output regwrite_w, rd_w, result_w,
    input  a1_d, a2_d, stall_d,
    input  valid_e, regwrite_e, memwrite_e, alusrc_e,
    input  resultsrc_e, alucontrol_e,
    input  rd1_e, rd2_e, immext_e, pc_e, pcplus4_e,
    input  rs1_e, rs2_e, rd_e, bubble_cnt
  );

  modport slave (
    input  instr_d, pc_d, pcplus4_d, valid_d,
    input  regwrite_d, memwrite_d, alusrc_d,
    input  resultsrc_d, alucontrol_d, immext_d,
    input  rd1_d, rd2_d,
    input  regwrite_w, rd_w, result_w,
    output a1_d, a2_d, stall_d,
    output valid_e, regwrite_e, memwrite_e, alusrc_e,
    output resultsrc_e, alucontrol_e,
    output rd1_e, rd2_e, immext_e, pc_e, pcplus4_e,
    output rs1_e, rs2_e, rd_e, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB->ID bypass and load-use bubble insertion.
// Bubbles are all-zero EX bundles; bubble_cnt saturates at 16'hFFFF.
module id_ex_stage (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memwrite;
    logic        alusrc;
    logic [1:0]  resultsrc;
    logic [2:0]  alucontrol;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } ex_t;

  ex_t         ex_q, ex_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  rs1, rs2, rd;
  logic        byp1, byp2;
  logic        hazard;
  logic        unused_instr;

  assign rs1 = bus.instr_d[19:15];
  assign rs2 = bus.instr_d[24:20];
  assign rd  = bus.instr_d[11:7];

  assign unused_instr = ^{bus.instr_d[31:25],
                          bus.instr_d[14:12],
                          bus.instr_d[6:0]};

  assign byp1 = bus.regwrite_w && (bus.rd_w != 5'd0)
             && (bus.rd_w == rs1);
  assign byp2 = bus.regwrite_w && (bus.rd_w != 5'd0)
             && (bus.rd_w == rs2);

  // Load in EX feeding a source of the decode instruction
  assign hazard = ex_q.valid
               && (ex_q.resultsrc == 2'b01)
               && (ex_q.rd != 5'd0)
               && bus.valid_d
               && ((ex_q.rd == rs1) || (ex_q.rd == rs2));

  always_comb begin
    ex_d = '0;
    if (bus.valid_d && !hazard) begin
      ex_d.valid      = 1'b1;
      ex_d.regwrite   = bus.regwrite_d;
      ex_d.memwrite   = bus.memwrite_d;
      ex_d.alusrc     = bus.alusrc_d;
      ex_d.resultsrc  = bus.resultsrc_d;
      ex_d.alucontrol = bus.alucontrol_d;
      ex_d.rd1        = byp1 ? bus.result_w : bus.rd1_d;
      ex_d.rd2        = byp2 ? bus.result_w : bus.rd2_d;
      ex_d.imm        = bus.immext_d;
      ex_d.pc         = bus.pc_d;
      ex_d.pcplus4    = bus.pcplus4_d;
      ex_d.rs1        = rs1;
      ex_d.rs2        = rs2;
      ex_d.rd         = rd;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hazard && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.a1_d         = rs1;
  assign bus.a2_d         = rs2;
  assign bus.stall_d      = hazard;
  assign bus.valid_e      = ex_q.valid;
  assign bus.regwrite_e   = ex_q.regwrite;
  assign bus.memwrite_e   = ex_q.memwrite;
  assign bus.alusrc_e     = ex_q.alusrc;
  assign bus.resultsrc_e  = ex_q.resultsrc;
  assign bus.alucontrol_e = ex_q.alucontrol;
  assign bus.rd1_e        = ex_q.rd1;
  assign bus.rd2_e        = ex_q.rd2;
  assign bus.immext_e     = ex_q.imm;
  assign bus.pc_e         = ex_q.pc;
  assign bus.pcplus4_e    = ex_q.pcplus4;
  assign bus.rs1_e        = ex_q.rs1;
  assign bus.rs2_e        = ex_q.rs2;
  assign bus.rd_e         = ex_q.rd;
  assign bus.bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table,
// randomized run against a reference model, saturation and reset cases.
`timescale 1ns/1ps
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memwrite;
    logic        alusrc;
    logic [1:0]  resultsrc;
    logic [2:0]  alucontrol;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } ex_t;

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic [1:0]  rsrc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        wrw;
    logic [4:0]  wrd;
    logic [31:0] wres;
    logic        stall;
    logic        ve;
    logic        rwe;
    logic [31:0] r1e;
    logic [31:0] r2e;
    logic [4:0]  s1e;
    logic [4:0]  s2e;
    logic [4:0]  rde;
    logic [15:0] cnt;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  ex_t  exp_ex;
  int   mcnt;
  vec_t tbl [17];

  task automatic chk(input string name,
                     input logic [191:0] act,
                     input logic [191:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mk(input int rd, input int rs1,
                                     input int rs2);
    logic [4:0] a, b, c;
    a = rd[4:0];
    b = rs1[4:0];
    c = rs2[4:0];
    return {7'd0, c, b, 3'd0, a, 7'h33};
  endfunction

  function automatic ex_t dut_ex();
    ex_t e;
    e.valid      = bus.valid_e;
    e.regwrite   = bus.regwrite_e;
    e.memwrite   = bus.memwrite_e;
    e.alusrc     = bus.alusrc_e;
    e.resultsrc  = bus.resultsrc_e;
    e.alucontrol = bus.alucontrol_e;
    e.rd1        = bus.rd1_e;
    e.rd2        = bus.rd2_e;
    e.imm        = bus.immext_e;
    e.pc         = bus.pc_e;
    e.pcplus4    = bus.pcplus4_e;
    e.rs1        = bus.rs1_e;
    e.rs2        = bus.rs2_e;
    e.rd         = bus.rd_e;
    return e;
  endfunction

  task automatic set_in(input logic [31:0] instr, input logic v,
                        input logic rw, input logic mw,
                        input logic as, input logic [1:0] rs,
                        input logic [2:0] ac, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [31:0] r1,
                        input logic [31:0] r2, input logic wrw,
                        input logic [4:0] wrd, input logic [31:0] wres);
    bus.instr_d      = instr;
    bus.valid_d      = v;
    bus.regwrite_d   = rw;
    bus.memwrite_d   = mw;
    bus.alusrc_d     = as;
    bus.resultsrc_d  = rs;
    bus.alucontrol_d = ac;
    bus.immext_d     = imm;
    bus.pc_d         = pc;
    bus.pcplus4_d    = pc + 32'd4;
    bus.rd1_d        = r1;
    bus.rd2_d        = r2;
    bus.regwrite_w   = wrw;
    bus.rd_w         = wrd;
    bus.result_w     = wres;
  endtask

  // Model: a register-file read sees the WB write of the same cycle
  function automatic logic [31:0] reg_read(input logic [4:0] a,
                                           input logic [31:0] raw);
    if (a != 5'd0 && bus.regwrite_w && bus.rd_w == a)
      return bus.result_w;
    return raw;
  endfunction

  function automatic logic m_hazard();
    logic [4:0] s1, s2;
    s1 = bus.instr_d[19:15];
    s2 = bus.instr_d[24:20];
    return exp_ex.valid && exp_ex.resultsrc == 2'b01
        && exp_ex.rd != 5'd0 && bus.valid_d
        && (exp_ex.rd == s1 || exp_ex.rd == s2);
  endfunction

  task automatic model_edge();
    ex_t n;
    n = '0;
    if (m_hazard()) begin
      if (mcnt < 65535) mcnt++;
    end else if (bus.valid_d) begin
      n.valid      = 1'b1;
      n.regwrite   = bus.regwrite_d;
      n.memwrite   = bus.memwrite_d;
      n.alusrc     = bus.alusrc_d;
      n.resultsrc  = bus.resultsrc_d;
      n.alucontrol = bus.alucontrol_d;
      n.rs1        = bus.instr_d[19:15];
      n.rs2        = bus.instr_d[24:20];
      n.rd         = bus.instr_d[11:7];
      n.rd1        = reg_read(n.rs1, bus.rd1_d);
      n.rd2        = reg_read(n.rs2, bus.rd2_d);
      n.imm        = bus.immext_d;
      n.pc         = bus.pc_d;
      n.pcplus4    = bus.pcplus4_d;
    end
    exp_ex = n;
  endtask

  // Called just after inputs are applied following a falling edge
  task automatic cycle_check(input string tag);
    #1;
    chk({tag, ".stall_d"}, 192'(bus.stall_d), 192'(m_hazard()));
    chk({tag, ".a1_d"}, 192'(bus.a1_d), 192'(bus.instr_d[19:15]));
    chk({tag, ".a2_d"}, 192'(bus.a2_d), 192'(bus.instr_d[24:20]));
    model_edge();
    @(posedge clk);
    #1;
    chk({tag, ".ex"}, 192'(dut_ex()), 192'(exp_ex));
    chk({tag, ".bubble_cnt"}, 192'(bus.bubble_cnt), 192'(mcnt));
  endtask

  initial begin
    tbl[0]  = '{mk(5,1,2), 1, 2'd0, 8, 9, 0, 0, 0,
                0, 1, 1, 8, 9, 1, 2, 5, 0};
    tbl[1]  = '{mk(6,2,0), 1, 2'd1, 100, 0, 0, 0, 0,
                0, 1, 1, 100, 0, 2, 0, 6, 0};
    tbl[2]  = '{mk(7,6,1), 1, 2'd0, 5, 3, 0, 0, 0,
                1, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[3]  = '{mk(7,6,1), 1, 2'd0, 50, 3, 0, 0, 0,
                0, 1, 1, 50, 3, 6, 1, 7, 1};
    tbl[4]  = '{mk(8,3,4), 1, 2'd0, 32'hAAAA_AAAA, 2,
                1, 3, 32'h1234_5678,
                0, 1, 1, 32'h1234_5678, 2, 3, 4, 8, 1};
    tbl[5]  = '{mk(9,0,0), 1, 2'd0, 0, 0, 1, 0, 32'hFFFF_FFFF,
                0, 1, 1, 0, 0, 0, 0, 9, 1};
    tbl[6]  = '{mk(0,1,0), 1, 2'd1, 4, 0, 0, 0, 0,
                0, 1, 1, 4, 0, 1, 0, 0, 1};
    tbl[7]  = '{mk(10,0,0), 1, 2'd0, 0, 0, 0, 0, 0,
                0, 1, 1, 0, 0, 0, 0, 10, 1};
    tbl[8]  = '{mk(16,10,10), 0, 2'd0, 1, 2, 0, 0, 0,
                0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[9]  = '{mk(11,1,0), 1, 2'd1, 4, 0, 0, 0, 0,
                0, 1, 1, 4, 0, 1, 0, 11, 1};
    tbl[10] = '{mk(12,11,2), 1, 2'd0, 9, 6, 1, 11, 32'hDEAD,
                1, 0, 0, 0, 0, 0, 0, 0, 2};
    tbl[11] = '{mk(12,11,2), 1, 2'd0, 32'hDEAD, 6, 0, 0, 0,
                0, 1, 1, 32'hDEAD, 6, 11, 2, 12, 2};
    tbl[12] = '{mk(13,1,0), 1, 2'd1, 4, 0, 0, 0, 0,
                0, 1, 1, 4, 0, 1, 0, 13, 2};
    tbl[13] = '{mk(14,1,13), 1, 2'd0, 1, 7, 0, 0, 0,
                1, 0, 0, 0, 0, 0, 0, 0, 3};
    tbl[14] = '{mk(14,1,13), 1, 2'd0, 1, 8, 0, 0, 0,
                0, 1, 1, 1, 8, 1, 13, 14, 3};
    tbl[15] = '{mk(15,2,0), 1, 2'd1, 3, 0, 0, 0, 0,
                0, 1, 1, 3, 0, 2, 0, 15, 3};
    tbl[16] = '{mk(16,15,15), 0, 2'd0, 1, 1, 0, 0, 0,
                0, 0, 0, 0, 0, 0, 0, 0, 3};

    // Reset state, with a decode pattern that would stall on a load in EX
    rst_n = 1'b0;
    set_in(mk(7,6,1), 1, 1, 1, 1, 2'd1, 3'd5, 1, 2, 3, 4, 1, 6, 9);
    #3;
    chk("reset.ex", 192'(dut_ex()), 192'(0));
    chk("reset.bubble_cnt", 192'(bus.bubble_cnt), 192'(0));
    chk("reset.stall_d", 192'(bus.stall_d), 192'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      if (i != 0) @(negedge clk);
      set_in(tbl[i].instr, tbl[i].valid, 1'b1, 1'b0, 1'b0,
             tbl[i].rsrc, 3'd0, 32'(i), 32'h100 + 32'(4 * i),
             tbl[i].r1, tbl[i].r2, tbl[i].wrw, tbl[i].wrd,
             tbl[i].wres);
      #1;
      chk({nm, ".stall_d"}, 192'(bus.stall_d), 192'(tbl[i].stall));
      @(posedge clk);
      #1;
      chk({nm, ".valid_e"}, 192'(bus.valid_e), 192'(tbl[i].ve));
      chk({nm, ".regwrite_e"}, 192'(bus.regwrite_e), 192'(tbl[i].rwe));
      chk({nm, ".rd1_e"}, 192'(bus.rd1_e), 192'(tbl[i].r1e));
      chk({nm, ".rd2_e"}, 192'(bus.rd2_e), 192'(tbl[i].r2e));
      chk({nm, ".rs1_e"}, 192'(bus.rs1_e), 192'(tbl[i].s1e));
      chk({nm, ".rs2_e"}, 192'(bus.rs2_e), 192'(tbl[i].s2e));
      chk({nm, ".rd_e"}, 192'(bus.rd_e), 192'(tbl[i].rde));
      chk({nm, ".bubble_cnt"}, 192'(bus.bubble_cnt), 192'(tbl[i].cnt));
    end

    // Randomized run; last table row leaves a bubble in EX
    exp_ex = '0;
    mcnt   = 3;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ins;
      @(negedge clk);
      ins = $urandom;
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      ins[11:7]  = 5'($urandom_range(0, 3));
      set_in(ins, ($urandom_range(0, 9) != 0), 1'($urandom),
             1'($urandom), 1'($urandom), 2'($urandom_range(0, 2)),
             3'($urandom), $urandom, $urandom, $urandom, $urandom,
             1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      cycle_check($sformatf("rnd%0d", i));
    end

    // Saturation: preload the counter just below its ceiling
    @(negedge clk);
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    mcnt = 65534;
    for (int k = 0; k < 2; k++) begin
      set_in(mk(6,2,0), 1, 1, 0, 0, 2'd1, 3'd0, 4, 32'h200, 7, 0,
             0, 0, 0);
      cycle_check($sformatf("sat%0d.lw", k));
      @(negedge clk);
      set_in(mk(7,6,1), 1, 1, 0, 0, 2'd0, 3'd0, 0, 32'h204, 1, 2,
             0, 0, 0);
      cycle_check($sformatf("sat%0d.use", k));
      @(negedge clk);
      cycle_check($sformatf("sat%0d.retry", k));
      @(negedge clk);
    end
    chk("sat.final", 192'(bus.bubble_cnt), 192'(16'hFFFF));

    // Asynchronous reset between edges with a stall pending
    set_in(mk(6,2,0), 1, 1, 1, 1, 2'd1, 3'd3, 4, 32'h300, 7, 0,
           0, 0, 0);
    cycle_check("ar.lw");
    @(negedge clk);
    set_in(mk(7,6,1), 1, 1, 0, 0, 2'd0, 3'd0, 0, 32'h304, 1, 2,
           0, 0, 0);
    #2;
    chk("ar.stall_before", 192'(bus.stall_d), 192'(1));
    rst_n = 1'b0;
    #1;
    chk("ar.ex", 192'(dut_ex()), 192'(0));
    chk("ar.bubble_cnt", 192'(bus.bubble_cnt), 192'(0));
    chk("ar.stall_d", 192'(bus.stall_d), 192'(0));
    #2;
    rst_n  = 1'b1;
    exp_ex = '0;
    mcnt   = 0;
    cycle_check("ar.resume");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
